// File: rtl/uart_btn_sequencer.sv
// Plays a fixed ASCII message to a valid/ready UART transmitter on each new button press.
// Optional macro UART_BTN_COUNT_EN appends the press count as two uppercase hex digits.
module uart_btn_sequencer #(
  parameter int                   MSG_LEN = 5,
  parameter logic [8*MSG_LEN-1:0] MSG     = "Hello"
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_db,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] press_cnt
);

  localparam int            IW       = $clog2(MSG_LEN + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);

`ifdef UART_BTN_COUNT_EN
  typedef enum logic [1:0] {IDLE, SEND, HEX_HI, HEX_LO} state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, idx_inc;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    press_cnt_q, press_cnt_d;
  logic          btn_prev_q;
  logic          press;

  // Byte 0 is the leftmost character of the string literal.
  logic [7:0] msg_rom [MSG_LEN];
  for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_rom
    assign msg_rom[gi] = MSG[8*(MSG_LEN-1-gi) +: 8];
  end

  assign press   = btn_prev_q & ~btn_db;
  assign idx_inc = idx_q + IW'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    press_cnt_d = press_cnt_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d     = SEND;
          idx_d       = '0;
          press_cnt_d = press_cnt_q + 8'd1;
          tx_data_d   = msg_rom[0];
          tx_valid_d  = 1'b1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q < LAST_IDX) begin
            idx_d     = idx_inc;
            tx_data_d = msg_rom[idx_inc];
          end else begin
`ifdef UART_BTN_COUNT_EN
            // press_cnt_q already holds the post-increment count here.
            state_d   = HEX_HI;
            tx_data_d = hex_ascii(press_cnt_q[7:4]);
`else
            state_d    = IDLE;
            tx_valid_d = 1'b0;
`endif
          end
        end
      end
`ifdef UART_BTN_COUNT_EN
      HEX_HI: begin
        if (tx_ready) begin
          state_d   = HEX_LO;
          tx_data_d = hex_ascii(press_cnt_q[3:0]);
        end
      end
      HEX_LO: begin
        if (tx_ready) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // btn_prev resets low so a button held through reset cannot fire a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      press_cnt_q <= 8'h00;
      btn_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      press_cnt_q <= press_cnt_d;
      btn_prev_q  <= btn_db;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = tx_valid_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_uart_btn_sequencer.sv
// Self-checking bench for uart_btn_sequencer: per-cycle vector table plus directed
// reset/held-button and (with UART_BTN_COUNT_EN) press-count wrap/hex sequences.
module tb_uart_btn_sequencer;

  logic       clk;
  logic       rst_n;
  logic       btn_db;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic [7:0] press_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_q[$];

  typedef struct packed {
    logic       btn;
    logic       rdy;
    logic       valid;
    logic [7:0] data;
    logic [7:0] cnt;
  } vec_t;

  vec_t vq[$];

  uart_btn_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_db    (btn_db),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .press_cnt (press_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      $display("tx byte 0x%02h cnt=%0d t=%0t", tx_data, press_cnt, $time);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic b, input logic r, input logic v,
                     input logic [7:0] d, input logic [7:0] c);
    vq.push_back('{btn: b, rdy: r, valid: v, data: d, cnt: c});
  endtask

  // Press, release, and wait (bounded) for the message to finish.
  task automatic press_msg();
    @(negedge clk);
    btn_db   = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    btn_db = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("msg_done", busy, 0);
  endtask

  string hello = "Hello";
  string hexs  = "0123456789ABCDEF";

  initial begin
    rst_n    = 1'b0;
    btn_db   = 1'b1;
    tx_ready = 1'b0;
    #1;
    check("rst_valid", tx_valid, 0);
    check("rst_busy",  busy, 0);
    check("rst_data",  tx_data, 8'h00);
    check("rst_cnt",   press_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

`ifndef UART_BTN_COUNT_EN
    // btn, ready, exp valid/busy, exp data (checked while valid), exp press_cnt
    add(1,0,0,8'h00,0); add(1,0,0,8'h00,0);
    // single press, ready held high
    add(0,1,1,8'h48,1); add(0,1,1,8'h65,1); add(0,1,1,8'h6C,1); add(0,1,1,8'h6C,1);
    add(0,1,1,8'h6F,1); add(0,1,0,8'h00,1); add(0,1,0,8'h00,1); add(1,1,0,8'h00,1);
    // backpressure with a 3-cycle stall before byte 2
    add(0,0,1,8'h48,2); add(1,1,1,8'h65,2); add(1,0,1,8'h65,2); add(1,0,1,8'h65,2);
    add(1,1,1,8'h6C,2); add(1,0,1,8'h6C,2); add(1,0,1,8'h6C,2); add(1,0,1,8'h6C,2);
    add(1,1,1,8'h6C,2); add(1,1,1,8'h6F,2); add(1,0,1,8'h6F,2); add(1,1,0,8'h00,2);
    // presses mid-message and on the final-acceptance edge are dropped
    add(0,1,1,8'h48,3); add(1,1,1,8'h65,3); add(0,1,1,8'h6C,3); add(1,1,1,8'h6C,3);
    add(1,1,1,8'h6F,3); add(0,1,0,8'h00,3); add(0,1,0,8'h00,3); add(1,1,0,8'h00,3);
    add(0,1,1,8'h48,4);

    foreach (vq[i]) begin
      @(negedge clk);
      btn_db   = vq[i].btn;
      tx_ready = vq[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), tx_valid, vq[i].valid);
      check($sformatf("v%0d_busy", i), busy, vq[i].valid);
      check($sformatf("v%0d_cnt", i), press_cnt, vq[i].cnt);
      if (vq[i].valid) check($sformatf("v%0d_data", i), tx_data, vq[i].data);
    end

    @(negedge clk);
    btn_db   = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("msg4_done", busy, 0);
    check("stream_len", got_q.size(), 20);
    for (int j = 0; j < 20 && j < got_q.size(); j++)
      check($sformatf("stream%0d", j), got_q[j], hello[j % 5]);
`else
    for (int k = 1; k <= 256; k++) begin
      got_q.delete();
      press_msg();
      if (k == 1 || k == 10 || k == 255 || k == 256) begin
        check($sformatf("p%0d_len", k), got_q.size(), 7);
        check($sformatf("p%0d_cnt", k), press_cnt, k % 256);
        if (got_q.size() == 7) begin
          for (int j = 0; j < 5; j++)
            check($sformatf("p%0d_b%0d", k, j), got_q[j], hello[j]);
          check($sformatf("p%0d_hi", k), got_q[5], hexs[(k % 256) / 16]);
          check($sformatf("p%0d_lo", k), got_q[6], hexs[(k % 256) % 16]);
        end
      end
    end
    check("p10_hi_lit", 8'h30, 8'h30 ^ 8'h00 ^ 8'h00 == 8'h30 ? 8'h30 : 8'h00);
`endif

    // button held low through reset deassertion: nothing happens
    @(negedge clk);
    btn_db   = 1'b0;
    tx_ready = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("held%0d_valid", i), tx_valid, 0);
    end
    check("held_cnt", press_cnt, 0);
    btn_db = 1'b1;
    @(negedge clk);
    btn_db = 1'b0;
    @(negedge clk);
    check("rel_press_valid", tx_valid, 1);
    check("rel_press_data", tx_data, 8'h48);
    check("rel_press_cnt", press_cnt, 1);
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_accepted", got_q.size(), 3);
    check("mid_data", tx_data, 8'h6C);
    rst_n = 1'b0;
    #1;
    check("abort_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", tx_data, 8'h00);
    check("abort_cnt", press_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post%0d_valid", i), tx_valid, 0);
    end
    check("post_accepted", got_q.size(), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_btn_sequencer.md
# uart_btn_sequencer

Sits directly downstream of the button debouncer and upstream of the UART transmitter. Detects each new press on the debounced, active-low button and plays out a fixed ASCII message to the transmitter, one byte per valid/ready handshake. Presses arriving while a message is in flight are dropped. An optional press counter is appended as two hex digits.

## Interface
- `MSG_LEN`, 5: number of message bytes, 1..255.
- `MSG`, "Hello": message, 8*MSG_LEN bits. Byte i is `MSG[8*(MSG_LEN-1-i) +: 8]`, so byte 0 is the leftmost character of a string literal.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_db` in 1: debounced button, already synchronous to `clk`. 1 = released, 0 = pressed.
- `tx_data` out 8: byte offered to the transmitter.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: transmitter accepts the byte on this edge.
- `busy` out 1: a message is in flight.
- `press_cnt` out 8: count of accepted presses, wraps from 255 to 0.

## Operation
- **Edge detect:**
  - Register `btn_prev` each cycle.
  - A press event is `btn_prev==1 && btn_db==0`.
  - `btn_prev` resets to 0, so a button held through reset produces nothing until it is released and pressed again.
- **States:**
  - IDLE: `tx_valid=0`, `busy=0`. A press event moves to SEND with `idx=0`, increments `press_cnt`, and loads `tx_data` with byte 0.
  - SEND: `tx_valid=1`, `busy=1`.
    - On each edge with `tx_valid && tx_ready`: if `idx<MSG_LEN-1`, increment `idx` and load the next byte on the same edge.
    - On the last byte: go to IDLE, or to HEX_HI when UART_BTN_COUNT_EN is defined.
  - HEX_HI / HEX_LO (macro only): send the upper nibble, then the lower nibble, of `press_cnt` as ASCII. HEX_LO acceptance returns to IDLE.
- **Handshake rules:**
  - A transfer occurs only on a rising edge where both `tx_valid` and `tx_ready` are 1.
  - While `tx_valid=1` and `tx_ready=0`, `tx_data` holds stable.
  - `tx_valid` never drops before acceptance.
  - Back-to-back bytes are allowed.
- **Dropped presses:**
  - A press event in any non-IDLE state is discarded. It is not queued and not counted.
  - This includes a press on the edge that accepts the final byte.
- **Holding the button:** a held button does not retrigger after the message ends. A new message requires 0→1→0 on `btn_db`.
- **Arithmetic:**
  - `idx` is `$clog2(MSG_LEN+1)` bits.
  - `press_cnt` is 8 bits and wraps modulo 256.
  - Hex digits are uppercase ASCII: 0x30–0x39 for 0–9, 0x41–0x46 for A–F.
- **Reset mid-message:** outputs return to reset values immediately, the message is abandoned, and the remaining bytes are not sent after reset.

## Timing
- Reset values: `tx_valid=0`, `tx_data=0x00`, `busy=0`, `press_cnt=0`, state IDLE, `idx=0`.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency: `btn_db` is first sampled 0 at edge N, and `tx_valid`/`busy`/`tx_data=byte0` are visible after edge N.
- With `tx_ready` held 1, byte k is accepted at edge N+1+k, and `busy`/`tx_valid` fall after edge N+MSG_LEN (N+MSG_LEN+2 with the macro).
- `press_cnt` updates at edge N. The hex digits show the post-increment value.

## Configuration
- Macro: `UART_BTN_COUNT_EN`.
- **Defined:** after the message, two extra bytes are sent: the ASCII hex of `press_cnt`, upper nibble first. The message is MSG_LEN+2 bytes.
- **Undefined:** the HEX states are not built and exactly MSG_LEN bytes are sent. `press_cnt` still counts and is output.

## Test plan
- **Single press:** reset, `tx_ready=1`, pull `btn_db` low at edge 10.
  - `tx_valid` is high for edges 11–15.
  - Accepted bytes are 0x48 0x65 0x6C 0x6C 0x6F.
  - `press_cnt=1`, then `busy=0`.
- **Backpressure:** `tx_ready` toggles 1,0,0,1,… and stalls 3 cycles before byte 2.
  - `tx_data` stays 0x6C and `tx_valid` stays high through the stall.
  - The full 5-byte sequence arrives in order.
- **Press during busy:** press, release, and press again at byte 2, plus a press on the final-acceptance edge.
  - Only one message is sent and `press_cnt=1`.
  - A later clean press sends a second message with `press_cnt=2`.
- **Held button and reset:**
  - Button held low through reset deassertion: no output.
  - Release, then press: one message.
  - Assert `rst_n` mid-message at byte 3: `tx_valid` drops 0 immediately, nothing resumes, and `press_cnt=0`.
- **Wrap and hex** (`UART_BTN_COUNT_EN`):
  - After 255 presses the trailing bytes are 0x46 0x46 ("FF").
  - Press 256 gives `press_cnt=0` and trailing bytes 0x30 0x30.
  - Press 10 gives 0x30 0x41.
